ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared 16x64 synchronous RAM (registered read on posedge, write on negedge, tri-stated output gated by cs).
- Each requester issues single-word reads/writes over a valid/ready handshake. The arbiter grants at most one RAM access per cycle and drives the RAM's address, enable and chip-select pins.
- It returns read data to the owning requester one cycle after grant.
- A lock input lets a requester hold the RAM for a bounded burst.

Parameters:
- WORDSIZE, 16, RAM data width
- ADDRSIZE, 6, RAM address width
- MAX_LOCK, 8, maximum consecutive grants a locked requester may hold (1..255)

Ports:
- clk  input  1  single clock; all state on posedge
- rst_n  input  1  asynchronous active-low reset
- req0_valid / req1_valid  input  1  request present
- req0_we / req1_we  input  1  1=write, 0=read
- req0_lock / req1_lock  input  1  requester wants to keep the grant next cycle
- req0_addr / req1_addr  input  ADDRSIZE  word address
- req0_wdata / req1_wdata  input  WORDSIZE  write data
- req0_ready / req1_ready  output  1  grant; transfer occurs when valid & ready
- rsp0_valid / rsp1_valid  output  1  read data valid (one-cycle pulse)
- rsp_rdata  output  WORDSIZE  read data, shared by both requesters, qualified by rsp*_valid
- ram_read_addr  output  ADDRSIZE  RAM read address
- ram_write_addr  output  ADDRSIZE  RAM write address
- ram_rd_en  output  1  RAM read enable
- ram_wr_en  output  1  RAM write enable
- ram_cs  output  1  RAM chip select (output enable)
- ram_data_in  output  WORDSIZE  data to RAM
- ram_data_out  input  WORDSIZE  data from RAM

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0; ram_data_in and both addresses are 0.
  - Priority pointer is reset to requester 0.
  - Lock counter is cleared.
  - Pending read response is discarded; no rsp pulse follows reset release.
- Arbitration (combinational from registered state):
  - Grant goes to the single valid requester, if only one is valid.
  - If both are valid, grant goes to the pointer's requester, unless a lock is held (see below).
  - reqN_ready = grant to N; ready is never asserted without valid.
- Pointer update on a grant without active lock: pointer moves to the other requester.
- Lock:
  - If the granted requester has lock=1 at its transfer, it keeps priority next cycle and lock_cnt increments.
  - When lock_cnt reaches MAX_LOCK-1, the lock is ignored: pointer moves and lock_cnt clears.
  - lock_cnt also clears on any grant with lock=0 or on an idle cycle.
- Write grant (cycle T):
  - ram_wr_en=1, ram_write_addr=addr, ram_data_in=wdata in the same cycle.
  - The RAM commits on the negedge of T.
- Read grant (cycle T):
  - ram_rd_en=1, ram_read_addr=addr in T.
  - FSM moves IDLE->RSP. In T+1: ram_cs=1, rspN_valid=1, rsp_rdata=ram_data_out.
  - RSP->IDLE at the end of T+1, unless a new read is granted in T+1, in which case it stays in RSP.
  - Back-to-back reads give one read per cycle.
- ram_cs is 1 only in RSP cycles; otherwise the RAM output floats.
- Read-after-write to the same address in consecutive cycles returns the new data, because the write commits at the negedge before the read's posedge.
- Only one access per cycle. ram_rd_en and ram_wr_en are never both 1.
- Idle cycle (no valid): all RAM enables are 0 and the pointer is unchanged.

Optional Feature:
- RAM_ARB_STATS_EN defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each) plus input stats_clr (1 bit).
  - Each counter counts transfers for its requester and saturates at 0xFFFF.
  - stats_clr=1 zeroes both counters next cycle and takes precedence over increments.
  - Counters reset to 0.
- Not defined: the ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset, then req0 writes 0xA5A5 to addr 3 at T, then req0 reads addr 3 at T+1 -> rsp0_valid=1 at T+2, rsp_rdata=0xA5A5, ram_cs=1 only in T+2.
- Both requesters valid continuously, no lock -> grants alternate 0,1,0,1; each ready is high in alternating cycles.
- req1 lock=1 held with both valid, MAX_LOCK=8 -> req1 gets 8 consecutive grants, then req0 is granted on the 9th cycle.
- Three back-to-back reads from req0 (addr 1, 2, 3 preloaded with 0x0011, 0x0022, 0x0033) -> rsp0_valid high for 3 cycles with rsp_rdata 0x0011, 0x0022, 0x0033.
- rst_n asserted in the cycle after a read grant -> no rsp pulse, all outputs 0 immediately, pointer at 0 after release.
- With RAM_ARB_STATS_EN: 5 req0 and 3 req1 transfers -> gnt_cnt0=5, gnt_cnt1=3; stats_clr=1 pulse -> both counters 0.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester handshake and RAM pin bundle for ram_arbiter.
// slave is the arbiter's view. master is the view of the requesters and the RAM.
interface ram_arbiter_if #(
    parameter int unsigned WORDSIZE = 16,
    parameter int unsigned ADDRSIZE = 6
);
    logic                req0_valid;
    logic                req0_we;
    logic                req0_lock;
    logic [ADDRSIZE-1:0] req0_addr;
    logic [WORDSIZE-1:0] req0_wdata;
    logic                req0_ready;

    logic                req1_valid;
    logic                req1_we;
    logic                req1_lock;
    logic [ADDRSIZE-1:0] req1_addr;
    logic [WORDSIZE-1:0] req1_wdata;
    logic                req1_ready;

    logic                rsp0_valid;
    logic                rsp1_valid;
    logic [WORDSIZE-1:0] rsp_rdata;

    logic [ADDRSIZE-1:0] ram_read_addr;
    logic [ADDRSIZE-1:0] ram_write_addr;
    logic                ram_rd_en;
    logic                ram_wr_en;
    logic                ram_cs;
    logic [WORDSIZE-1:0] ram_data_in;
    logic [WORDSIZE-1:0] ram_data_out;

    modport slave (
        input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        input  ram_data_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
        output ram_read_addr, ram_write_addr, ram_rd_en, ram_wr_en, ram_cs, ram_data_in
    );

    modport master (
        output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
        output ram_data_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
        input  ram_read_addr, ram_write_addr, ram_rd_en, ram_wr_en, ram_cs, ram_data_in
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester round-robin arbiter and sequencer for a shared synchronous RAM.
// The RAM registers its read data on posedge and commits writes on negedge.
// Its output drives only while cs is high.
// Defining RAM_ARB_STATS_EN adds saturating per-requester transfer counters with a clear input.
module ram_arbiter #(
    parameter int unsigned WORDSIZE = 16,
    parameter int unsigned ADDRSIZE = 6,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef RAM_ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] gnt_cnt0,
    output logic [15:0] gnt_cnt1,
`endif
    ram_arbiter_if.slave bus
);
    typedef enum logic {StIdle, StRsp} state_e;

    // A locked grant taken at this count is the last one of the burst.
    localparam logic [7:0] LockLast = 8'(MAX_LOCK - 1);

    state_e     state_q, state_d;
    logic       ptr_q, ptr_d;       // requester favoured when both are valid
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       owner_q, owner_d;   // requester whose read data is on the RAM output

    logic                gnt0, gnt1, gnt_any, gnt_we, gnt_lock, gnt_rd, gnt_wr;
    logic [ADDRSIZE-1:0] gnt_addr;
    logic [WORDSIZE-1:0] gnt_wdata;

    // Grant selection and winner mux. Gated by rst_n so outputs drop to 0 the instant reset asserts.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = ~ptr_q;
                gnt1 = ptr_q;
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
        gnt_any   = gnt0 | gnt1;
        gnt_we    = gnt1 ? bus.req1_we    : bus.req0_we;
        gnt_lock  = gnt1 ? bus.req1_lock  : bus.req0_lock;
        gnt_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
        gnt_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;
        gnt_rd    = gnt_any & ~gnt_we;
        gnt_wr    = gnt_any & gnt_we;
    end

    // Next-state: pointer/lock bookkeeping and the read-response sequencer.
    always_comb begin
        ptr_d      = ptr_q;
        lock_cnt_d = '0;
        owner_d    = owner_q;
        state_d    = StIdle;
        if (gnt_any) begin
            if (gnt_lock && (lock_cnt_q < LockLast)) begin
                ptr_d      = gnt1;
                lock_cnt_d = lock_cnt_q + 8'd1;
            end else begin
                ptr_d = gnt0;
            end
        end
        if (gnt_rd) begin
            state_d = StRsp;
            owner_d = gnt1;
        end
    end

    // RAM pins and requester outputs. Unused addresses and data are held at 0.
    always_comb begin
        bus.req0_ready     = gnt0;
        bus.req1_ready     = gnt1;
        bus.ram_rd_en      = gnt_rd;
        bus.ram_wr_en      = gnt_wr;
        bus.ram_read_addr  = gnt_rd ? gnt_addr : '0;
        bus.ram_write_addr = gnt_wr ? gnt_addr : '0;
        bus.ram_data_in    = gnt_wr ? gnt_wdata : '0;
        bus.ram_cs         = (state_q == StRsp);
        bus.rsp0_valid     = (state_q == StRsp) & ~owner_q;
        bus.rsp1_valid     = (state_q == StRsp) & owner_q;
        // The RAM output floats outside response cycles, so never pass it through then.
        bus.rsp_rdata      = (state_q == StRsp) ? bus.ram_data_out : '0;
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= 1'b0;
            lock_cnt_q <= '0;
            owner_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            owner_q    <= owner_d;
        end
    end

`ifdef RAM_ARB_STATS_EN
    // Saturating transfer counters. A clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else if (stats_clr) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0 && (gnt_cnt0 != 16'hFFFF)) gnt_cnt0 <= gnt_cnt0 + 16'd1;
            if (gnt1 && (gnt_cnt1 != 16'hFFFF)) gnt_cnt1 <= gnt_cnt1 + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a cycle-level reference model.
// The bench contains a behavioural RAM model.
// Define RAM_ARB_STATS_EN to include the grant-counter checks.
module tb_ram_arbiter;
    localparam int unsigned W  = 16;
    localparam int unsigned A  = 6;
    localparam int          ML = 8;

    typedef struct packed {
        logic         valid;
        logic         we;
        logic         lock;
        logic [A-1:0] addr;
        logic [W-1:0] wdata;
    } req_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_if #(.WORDSIZE(W), .ADDRSIZE(A)) bus ();

`ifdef RAM_ARB_STATS_EN
    logic        stats_clr = 1'b0;
    logic        clr_next  = 1'b0;
    logic [15:0] gnt_cnt0, gnt_cnt1;
    int          m_cnt0, m_cnt1;
`endif

    ram_arbiter #(.WORDSIZE(W), .ADDRSIZE(A), .MAX_LOCK(ML)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef RAM_ARB_STATS_EN
        .stats_clr (stats_clr),
        .gnt_cnt0  (gnt_cnt0),
        .gnt_cnt1  (gnt_cnt1),
`endif
        .bus       (bus)
    );

    // Behavioural RAM: registered read on posedge, write on negedge, output valid only with cs.
    logic [W-1:0] ram_mem [2**A];
    logic [W-1:0] ram_q;
    always @(negedge clk) if (bus.ram_wr_en) ram_mem[bus.ram_write_addr] <= bus.ram_data_in;
    always @(posedge clk) if (bus.ram_rd_en) ram_q <= ram_mem[bus.ram_read_addr];
    assign bus.ram_data_out = bus.ram_cs ? ram_q : {W{1'bx}};

    // Reference model state.
    int           m_prio;
    int           m_run;
    bit           m_pend;
    int           m_pend_owner;
    logic [W-1:0] m_pend_data;
    logic [W-1:0] m_mem [2**A];

    int compared   = 0;
    int mismatched = 0;

    req_t idle_r = '0;

    function automatic req_t mk(input logic v, input logic we, input logic lk,
                                input logic [A-1:0] a, input logic [W-1:0] d);
        req_t r;
        r.valid = v;
        r.we    = we;
        r.lock  = lk;
        r.addr  = a;
        r.wdata = d;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input req_t r0, input req_t r1);
        bus.req0_valid = r0.valid;
        bus.req0_we    = r0.we;
        bus.req0_lock  = r0.lock;
        bus.req0_addr  = r0.addr;
        bus.req0_wdata = r0.wdata;
        bus.req1_valid = r1.valid;
        bus.req1_we    = r1.we;
        bus.req1_lock  = r1.lock;
        bus.req1_addr  = r1.addr;
        bus.req1_wdata = r1.wdata;
    endtask

    task automatic check_zero();
        chk("rst_req0_ready", 32'(bus.req0_ready), 32'd0);
        chk("rst_req1_ready", 32'(bus.req1_ready), 32'd0);
        chk("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rd_en", 32'(bus.ram_rd_en), 32'd0);
        chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
        chk("rst_cs", 32'(bus.ram_cs), 32'd0);
        chk("rst_read_addr", 32'(bus.ram_read_addr), 32'd0);
        chk("rst_write_addr", 32'(bus.ram_write_addr), 32'd0);
        chk("rst_data_in", 32'(bus.ram_data_in), 32'd0);
`ifdef RAM_ARB_STATS_EN
        chk("rst_gnt_cnt0", 32'(gnt_cnt0), 32'd0);
        chk("rst_gnt_cnt1", 32'(gnt_cnt1), 32'd0);
`endif
    endtask

    // Assert reset in the current cycle, leaving inputs as they are, then release it one cycle later.
    task automatic reset_check();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #3;
        check_zero();
        drive(idle_r, idle_r);
        m_prio = 0;
        m_run  = 0;
        m_pend = 1'b0;
`ifdef RAM_ARB_STATS_EN
        m_cnt0 = 0;
        m_cnt1 = 0;
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive requests, compare every output with the model, advance the model.
    task automatic step(input req_t r0, input req_t r1);
        int   win;
        req_t g;
        bit   e_rd, e_wr;
        @(posedge clk);
        #1;
        drive(r0, r1);
`ifdef RAM_ARB_STATS_EN
        stats_clr = clr_next;
`endif
        #3;
        win = -1;
        if (r0.valid && r1.valid) win = m_prio;
        else if (r0.valid)        win = 0;
        else if (r1.valid)        win = 1;
        g    = (win == 1) ? r1 : r0;
        e_rd = (win >= 0) && !g.we;
        e_wr = (win >= 0) && g.we;

        chk("req0_ready", 32'(bus.req0_ready), 32'(win == 0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(win == 1));
        chk("ram_rd_en", 32'(bus.ram_rd_en), 32'(e_rd));
        chk("ram_wr_en", 32'(bus.ram_wr_en), 32'(e_wr));
        chk("ram_cs", 32'(bus.ram_cs), 32'(m_pend));
        chk("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_pend && m_pend_owner == 0));
        chk("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_pend && m_pend_owner == 1));
        chk("rsp_rdata", 32'(bus.rsp_rdata), m_pend ? 32'(m_pend_data) : 32'd0);
        chk("ram_read_addr", 32'(bus.ram_read_addr), e_rd ? 32'(g.addr) : 32'd0);
        chk("ram_write_addr", 32'(bus.ram_write_addr), e_wr ? 32'(g.addr) : 32'd0);
        chk("ram_data_in", 32'(bus.ram_data_in), e_wr ? 32'(g.wdata) : 32'd0);
`ifdef RAM_ARB_STATS_EN
        chk("gnt_cnt0", 32'(gnt_cnt0), 32'(m_cnt0));
        chk("gnt_cnt1", 32'(gnt_cnt1), 32'(m_cnt1));
        if (clr_next) begin
            m_cnt0 = 0;
            m_cnt1 = 0;
        end else begin
            if (win == 0 && m_cnt0 < 65535) m_cnt0++;
            if (win == 1 && m_cnt1 < 65535) m_cnt1++;
        end
`endif
        m_pend = e_rd;
        if (e_rd) begin
            m_pend_owner = win;
            m_pend_data  = m_mem[g.addr];
        end
        if (e_wr) m_mem[g.addr] = g.wdata;
        if (win < 0) begin
            m_run = 0;
        end else if (g.lock && (m_run + 1 < ML)) begin
            m_prio = win;
            m_run++;
        end else begin
            m_prio = 1 - win;
            m_run  = 0;
        end
    endtask

    initial begin
        drive(idle_r, idle_r);
        reset_check();

        // Fill the RAM through the arbiter so every address holds known data.
        for (int i = 0; i < 2**A; i++) step(mk(1'b1, 1'b1, 1'b0, A'(i), W'($urandom)), idle_r);

        // Write then read back through req0.
        step(mk(1'b1, 1'b1, 1'b0, 6'd3, 16'hA5A5), idle_r);
        chk("wr_cs_low", 32'(bus.ram_cs), 32'd0);
        step(mk(1'b1, 1'b0, 1'b0, 6'd3, 16'h0), idle_r);
        chk("rd_cs_low", 32'(bus.ram_cs), 32'd0);
        step(idle_r, idle_r);
        chk("raw_cs", 32'(bus.ram_cs), 32'd1);
        chk("raw_rsp0", 32'(bus.rsp0_valid), 32'd1);
        chk("raw_rdata", 32'(bus.rsp_rdata), 32'h0000A5A5);
        step(idle_r, idle_r);
        chk("raw_cs_after", 32'(bus.ram_cs), 32'd0);

        // A lone req1 grant moves priority to req0. Then both valid alternate.
        step(idle_r, mk(1'b1, 1'b1, 1'b0, 6'd10, 16'h1111));
        for (int i = 0; i < 4; i++) begin
            step(mk(1'b1, 1'b1, 1'b0, 6'd20, 16'h2000), mk(1'b1, 1'b1, 1'b0, 6'd21, 16'h2100));
            chk("alt_ready0", 32'(bus.req0_ready), 32'(i % 2 == 0));
        end

        // req1 holds lock: one req0 grant, eight req1 grants, then req0.
        for (int i = 0; i < 10; i++) begin
            step(mk(1'b1, 1'b1, 1'b0, 6'd30, 16'h3000), mk(1'b1, 1'b1, 1'b1, 6'd31, 16'h3100));
            chk("lock_ready1", 32'(bus.req1_ready), 32'(i >= 1 && i <= 8));
        end

        // Back-to-back reads.
        step(mk(1'b1, 1'b1, 1'b0, 6'd1, 16'h0011), idle_r);
        step(mk(1'b1, 1'b1, 1'b0, 6'd2, 16'h0022), idle_r);
        step(mk(1'b1, 1'b1, 1'b0, 6'd3, 16'h0033), idle_r);
        step(mk(1'b1, 1'b0, 1'b0, 6'd1, 16'h0), idle_r);
        step(mk(1'b1, 1'b0, 1'b0, 6'd2, 16'h0), idle_r);
        chk("b2b_rsp0_a", 32'(bus.rsp0_valid), 32'd1);
        chk("b2b_rdata_a", 32'(bus.rsp_rdata), 32'h0011);
        step(mk(1'b1, 1'b0, 1'b0, 6'd3, 16'h0), idle_r);
        chk("b2b_rsp0_b", 32'(bus.rsp0_valid), 32'd1);
        chk("b2b_rdata_b", 32'(bus.rsp_rdata), 32'h0022);
        step(idle_r, idle_r);
        chk("b2b_rsp0_c", 32'(bus.rsp0_valid), 32'd1);
        chk("b2b_rdata_c", 32'(bus.rsp_rdata), 32'h0033);

        // Reset in the cycle after a read grant: no response, priority back at req0.
        step(mk(1'b1, 1'b0, 1'b0, 6'd5, 16'h0), idle_r);
        reset_check();
        step(idle_r, idle_r);
        chk("rst_no_rsp", 32'(bus.rsp0_valid), 32'd0);
        step(mk(1'b1, 1'b1, 1'b0, 6'd40, 16'h4000), mk(1'b1, 1'b1, 1'b0, 6'd41, 16'h4100));
        chk("rst_ptr_req0", 32'(bus.req0_ready), 32'd1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
`ifdef RAM_ARB_STATS_EN
            clr_next = ($urandom_range(0, 19) == 0);
`endif
            step(mk($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, A'($urandom), W'($urandom)),
                 mk($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) == 0, A'($urandom), W'($urandom)));
        end

`ifdef RAM_ARB_STATS_EN
        clr_next = 1'b0;
        reset_check();
        for (int i = 0; i < 5; i++) step(mk(1'b1, 1'b1, 1'b0, 6'd50, 16'h5000), idle_r);
        for (int i = 0; i < 3; i++) step(idle_r, mk(1'b1, 1'b1, 1'b0, 6'd51, 16'h5100));
        step(idle_r, idle_r);
        chk("stats_cnt0", 32'(gnt_cnt0), 32'd5);
        chk("stats_cnt1", 32'(gnt_cnt1), 32'd3);
        clr_next = 1'b1;
        step(idle_r, idle_r);
        clr_next = 1'b0;
        step(idle_r, idle_r);
        chk("stats_clr0", 32'(gnt_cnt0), 32'd0);
        chk("stats_clr1", 32'(gnt_cnt1), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
